// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone classic initiator.
// The optional bus timeout is enabled by defining WB_TIMEOUT_EN.
package wb_pkg;

   localparam int WB_ADDR_W = 32;
   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;
   localparam int WB_TMO_W  = 16;

   typedef enum logic [1:0] {
      WBI_IDLE,
      WBI_BUS,
      WBI_RESP
   } wbi_state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts bus cycles spent waiting for a target response.
// Only instantiated when WB_TIMEOUT_EN is defined.
module wb_timeout_counter
   import wb_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic clk_in,
   input  logic reset_in,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [WB_TMO_W-1:0] LAST_COUNT = WB_TMO_W'(TimeoutCycles - 1);

   logic [WB_TMO_W-1:0] count_q;

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + 1'b1;
      end
   end

   // The caller decides priority against ack/err; this only flags the last waiting cycle.
   assign terminal = (count_q == LAST_COUNT);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one valid/ready request becomes one single-beat bus cycle.
// Define WB_TIMEOUT_EN to abort cycles the target never terminates.
module wb_initiator
   import wb_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic                 clk_in,
   input  logic                 reset_in,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [WB_ADDR_W-1:0] req_addr,
   input  logic [WB_DATA_W-1:0] req_wdata,
   input  logic [WB_SEL_W-1:0]  req_sel,
   output logic                 rsp_valid,
   output logic [WB_DATA_W-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 wb_cyc,
   output logic                 wb_stb,
   output logic                 wb_we,
   output logic [WB_SEL_W-1:0]  wb_sel,
   output logic [WB_ADDR_W-1:0] wb_addr,
   output logic [WB_DATA_W-1:0] wb_wdata,
   input  logic                 wb_ack,
   input  logic                 wb_err,
   input  logic [WB_DATA_W-1:0] wb_rdata,
   output wbi_state_t           state_dbg
);

   // Handshake: a request transfers on a clock edge where req_valid & req_ready;
   // rsp_valid is a single-cycle strobe with no backpressure.

   if (TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_timeout
      $error("wb_initiator: TimeoutCycles must be in 1..65535");
   end

   wbi_state_t           state_q, state_d;
   logic                 we_q;
   logic [WB_ADDR_W-1:0] addr_q;
   logic [WB_DATA_W-1:0] wdata_q;
   logic [WB_SEL_W-1:0]  sel_q;
   logic [WB_DATA_W-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic                 accept;
   logic                 in_bus;
   logic                 tmo_hit;

   assign in_bus = (state_q == WBI_BUS);
   assign accept = req_valid && (state_q == WBI_IDLE);

`ifdef WB_TIMEOUT_EN
   logic tmo_terminal;

   // Held in clear outside BUS, so every bus cycle starts counting from zero.
   wb_timeout_counter #(
      .TimeoutCycles(TimeoutCycles)
   ) u_timeout (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .clear    (!in_bus),
      .enable   (in_bus && !wb_ack && !wb_err),
      .terminal (tmo_terminal)
   );

   assign tmo_hit = in_bus && tmo_terminal;
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         WBI_IDLE: begin
            if (req_valid) begin
               rdata_d = '0;
               if (req_sel != '0) begin
                  state_d = WBI_BUS;
                  err_d   = 1'b0;
               end else begin
                  state_d = WBI_RESP;
                  err_d   = 1'b1;
               end
            end
         end
         WBI_BUS: begin
            // Error beats ack; a real termination beats the timeout.
            if (wb_err) begin
               state_d = WBI_RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else if (wb_ack) begin
               state_d = WBI_RESP;
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : wb_rdata;
            end else if (tmo_hit) begin
               state_d = WBI_RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         WBI_RESP: begin
            state_d = WBI_IDLE;
         end
         default: begin
            state_d = WBI_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q <= WBI_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            sel_q   <= req_sel;
         end
      end
   end

   // All outputs decode from registers only, so reset drops the bus at once.
   assign req_ready = (state_q == WBI_IDLE);
   assign busy      = (state_q != WBI_IDLE);
   assign rsp_valid = (state_q == WBI_RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign wb_cyc    = in_bus;
   assign wb_stb    = in_bus;
   assign wb_we     = in_bus && we_q;
   assign wb_sel    = in_bus ? sel_q   : '0;
   assign wb_addr   = in_bus ? addr_q  : '0;
   assign wb_wdata  = in_bus ? wdata_q : '0;
   assign state_dbg = state_q;

endmodule
